// File: rtl/data_handler.sv
`default_nettype none
// ============================================================================
// Module   : data_handler
// Brief    : UART framing bridge (8N1) between an NBYTES-byte code word and
//            the serial link. RX assembles NBYTES bytes into one word and
//            strobes datavalid; TX serialises a word on a senddata edge.
//            Bytes travel MSB-byte first, bits LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module data_handler #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int NBYTES       = 10,
    parameter int RX_TIMEOUT   = 20 * CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX,
    input  logic [8*NBYTES-1:0]   idata,
    input  logic                  senddata,
    output logic [8*NBYTES-1:0]   odata,
    output logic                  datavalid,
    output logic                  TX
);

    localparam int c_DW = 8 * NBYTES;
    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_JW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int c_KW = $clog2(NBYTES + 1);
    localparam int c_TW = $clog2(RX_TIMEOUT + 1);

    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_JW-1:0] c_J_LAST    = c_JW'(NBYTES - 1);
    localparam logic [c_KW-1:0] c_K_FULL    = c_KW'(NBYTES);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(RX_TIMEOUT - 1);

    // Shared state encoding for both serial engines
    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------
    logic              r_rx_meta;
    logic              r_rx_sync;
    logic [1:0]        r_rx_state;
    logic [1:0]        w_rx_state_n;
    logic [c_CW-1:0]   r_rx_cnt;
    logic [c_CW-1:0]   w_rx_cnt_n;
    logic [2:0]        r_rx_bit;
    logic [2:0]        w_rx_bit_n;
    logic [7:0]        r_rx_shift;
    logic [7:0]        w_rx_shift_n;
    logic              w_rx_accept;

    logic [c_DW-1:0]   r_rx_word;
    logic [c_KW-1:0]   r_rx_k;
    logic [c_TW-1:0]   r_idle_cnt;
    logic [c_DW-1:0]   r_odata;
    logic              r_datavalid;
    logic              w_word_done;
    logic              w_partial;
    logic              w_timeout;

    // Two-flop synchroniser for the asynchronous RX pin, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= c_S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    // RX next state: half-bit start re-check, then mid-bit sampling
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_accept  = 1'b0;
        case (r_rx_state)
            c_S_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_n = c_S_START;
                    w_rx_cnt_n   = '0;
                end
            end
            c_S_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    // A start bit that has gone high again was only a glitch
                    w_rx_state_n = r_rx_sync ? c_S_IDLE : c_S_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            c_S_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = c_S_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            c_S_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = c_S_IDLE;
                    // A low stop bit is a framing error: the byte is dropped
                    w_rx_accept  = r_rx_sync;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_n = c_S_IDLE;
        endcase
    end

    assign w_word_done = (r_rx_k == c_K_FULL);
    assign w_partial   = (r_rx_k != '0) && !w_word_done;
    assign w_timeout   = w_partial && (r_rx_state == c_S_IDLE) && (r_idle_cnt == c_TO_LAST);

    // Idle-line counter, only running while a word is partially assembled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (!w_partial || (r_rx_state != c_S_IDLE) || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Word assembly: publish the word one cycle after the last byte lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_word   <= '0;
            r_rx_k      <= '0;
            r_odata     <= '0;
            r_datavalid <= 1'b0;
        end else if (w_word_done) begin
            r_odata     <= r_rx_word;
            r_datavalid <= 1'b1;
            r_rx_k      <= '0;
        end else begin
            r_datavalid <= 1'b0;
            if (w_rx_accept) begin
                r_rx_word <= (r_rx_word << 8) | c_DW'(r_rx_shift);
                r_rx_k    <= r_rx_k + 1'b1;
            end else if (w_timeout) begin
                r_rx_k <= '0;
            end
        end
    end

    assign odata     = r_odata;
    assign datavalid = r_datavalid;

    // ------------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------------
    logic              r_send_q;
    logic              w_send_req;
    logic [1:0]        r_tx_state;
    logic [1:0]        w_tx_state_n;
    logic [c_CW-1:0]   r_tx_cnt;
    logic [c_CW-1:0]   w_tx_cnt_n;
    logic [2:0]        r_tx_bit;
    logic [2:0]        w_tx_bit_n;
    logic [c_JW-1:0]   r_tx_j;
    logic [c_JW-1:0]   w_tx_j_n;
    logic [c_DW-1:0]   r_tx_buf;
    logic [c_DW-1:0]   w_tx_buf_n;
    logic [7:0]        w_tx_cur;
    logic              w_tx_n;
    logic              r_tx;

    assign w_send_req = senddata & ~r_send_q;

    // TX engine next state; the buffer shifts up a byte after each stop bit
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_j_n     = r_tx_j;
        w_tx_buf_n   = r_tx_buf;
        case (r_tx_state)
            c_S_IDLE: begin
                if (w_send_req) begin
                    w_tx_state_n = c_S_START;
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_j_n     = '0;
                    w_tx_buf_n   = idata;
                end
            end
            c_S_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = c_S_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            c_S_DATA: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = c_S_STOP;
                    end else begin
                        w_tx_bit_n = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            c_S_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_j == c_J_LAST) begin
                        w_tx_state_n = c_S_IDLE;
                    end else begin
                        w_tx_state_n = c_S_START;
                        w_tx_j_n     = r_tx_j + 1'b1;
                        w_tx_buf_n   = r_tx_buf << 8;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_n = c_S_IDLE;
        endcase

        // Line level for the upcoming cycle, registered to keep TX glitch-free
        w_tx_cur = w_tx_buf_n[c_DW-1 -: 8];
        case (w_tx_state_n)
            c_S_START: w_tx_n = 1'b0;
            c_S_DATA:  w_tx_n = w_tx_cur[w_tx_bit_n];
            default:   w_tx_n = 1'b1;
        endcase
    end

    // TX engine state register, request edge detector and line driver
    always_ff @(posedge clk) begin
        if (rst) begin
            r_send_q   <= 1'b0;
            r_tx_state <= c_S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_j     <= '0;
            r_tx_buf   <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_send_q   <= senddata;
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_j     <= w_tx_j_n;
            r_tx_buf   <= w_tx_buf_n;
            r_tx       <= w_tx_n;
        end
    end

    assign TX = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_data_handler.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_handler
// Brief    : Self-checking bench for data_handler with RX/TX scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_handler;

    localparam int CPB = 16;
    localparam int NB  = 10;
    localparam int DW  = 8 * NB;
    localparam int TO  = 20 * CPB;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          rx_tb     = 1'b1;
    logic          senddata  = 1'b0;
    logic          loop_en   = 1'b0;
    logic          tx_mon_en = 1'b1;
    logic [DW-1:0] idata     = '0;
    logic [DW-1:0] odata;
    logic          datavalid;
    logic          tx;
    logic          rx_in;

    int n_checks = 0;
    int n_errors = 0;
    int dv_count = 0;
    int exp_dv   = 0;
    int tx_bytes = 0;
    int base_tx  = 0;

    logic [DW-1:0] rx_q[$];
    logic [7:0]    tx_q[$];

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] exp;
    } rx_vec_t;

    rx_vec_t       rv[4];
    logic [DW-1:0] tv[3];
    logic [9:0]    pat;
    logic [DW-1:0] w;

    assign rx_in = loop_en ? tx : rx_tb;

    data_handler #(
        .CLKS_PER_BIT (CPB),
        .NBYTES       (NB),
        .RX_TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx_in),
        .idata     (idata),
        .senddata  (senddata),
        .odata     (odata),
        .datavalid (datavalid),
        .TX        (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        rx_tb = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_tb = b[i];
            tick(CPB);
        end
        rx_tb = stop;
        tick(CPB);
        if (!stop) begin
            rx_tb = 1'b1;
            tick(2 * CPB);
        end
        rx_tb = 1'b1;
    endtask

    task automatic rx_word(input logic [DW-1:0] wd);
        for (int i = 0; i < NB; i++) rx_byte(wd[DW-1-8*i -: 8], 1'b1);
    endtask

    task automatic rx_expect(input logic [DW-1:0] wd);
        rx_q.push_back(wd);
        exp_dv++;
    endtask

    task automatic wait_rx_drain(input string name);
        for (int i = 0; i < 100 && rx_q.size() != 0; i++) tick(1);
        check(name, DW'(rx_q.size()), '0);
        rx_q.delete();
    endtask

    task automatic tx_send(input logic [DW-1:0] wd, input bit push);
        idata = wd;
        if (push) begin
            for (int i = 0; i < NB; i++) tx_q.push_back(wd[DW-1-8*i -: 8]);
        end
        senddata = 1'b1;
        tick(1);
        senddata = 1'b0;
    endtask

    task automatic wait_tx_drain(input string name);
        for (int i = 0; i < NB * 10 * CPB + 200 && tx_q.size() != 0; i++) tick(1);
        check(name, DW'(tx_q.size()), '0);
        tx_q.delete();
        tick(CPB);
    endtask

    // Scoreboard for received words
    always @(negedge clk) begin
        if (!rst && datavalid === 1'b1) begin
            dv_count++;
            if (rx_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rx_unexpected_dv: got odata=%h expected no datavalid", odata);
            end else begin
                check("rx_word", odata, rx_q.pop_front());
            end
        end
    end

    // Serial decoder on TX feeding the transmit scoreboard
    initial begin : tx_mon
        logic [7:0] b;
        logic       stp;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_mon_en && !rst && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (CPB) @(negedge clk);
                    stp = tx;
                    if (tx_mon_en) begin
                        tx_bytes++;
                        if (tx_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL tx_unexpected_byte: got %h expected no byte", b);
                        end else begin
                            e = tx_q.pop_front();
                            check("tx_byte", DW'(b), DW'(e));
                            check("tx_stop", DW'(stp), DW'(1));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit expired expected self-termination");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        rv[0] = '{word: 80'hA55A_00FF_1122_3344_5566, exp: 80'hA55A_00FF_1122_3344_5566};
        rv[1] = '{word: 80'h0000_0000_0000_0000_0000, exp: 80'h0000_0000_0000_0000_0000};
        rv[2] = '{word: 80'hFFFF_FFFF_FFFF_FFFF_FFFF, exp: 80'hFFFF_FFFF_FFFF_FFFF_FFFF};
        rv[3] = '{word: 80'h8001_7FFE_C33C_0FF0_AA55, exp: 80'h8001_7FFE_C33C_0FF0_AA55};
        tv[0] = 80'h0000_0000_0000_0000_0000;
        tv[1] = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        tv[2] = 80'h80C3_3C01_A55A_FE7F_1248;

        // Reset held two cycles
        rst = 1'b1;
        tick(2);
        check("rst_tx", DW'(tx), DW'(1));
        check("rst_dv", DW'(datavalid), '0);
        check("rst_odata", odata, '0);
        rst = 1'b0;
        tick(2);

        // Transmit: framing of first byte and total duration
        tx_send(80'h0102_0304_0506_0708_090A, 1'b1);
        check("tx_start_latency", DW'(tx), '0);
        pat = 10'b10_0000_0010;
        tick(CPB / 2);
        for (int i = 0; i < 10; i++) begin
            check("tx_byte0_bit", DW'(tx), DW'(pat[i]));
            tick(CPB);
        end
        tick(1584 - (1 + CPB / 2 + 10 * CPB));
        check("tx_last_data_bit", DW'(tx), '0);
        tick(1);
        check("tx_last_stop", DW'(tx), DW'(1));
        tick(CPB);
        check("tx_idle_after", DW'(tx), DW'(1));
        wait_tx_drain("tx_drain_basic");
        tick(4 * CPB);
        check("tx_byte_count", DW'(tx_bytes), DW'(NB));

        // Receive table
        for (int i = 0; i < 4; i++) begin
            rx_expect(rv[i].exp);
            rx_word(rv[i].word);
            wait_rx_drain("rx_table_drain");
        end

        // Framing error on byte 3 is dropped without advancing the index
        rx_expect(80'h1020_3040_4142_4344_4546);
        rx_byte(8'h10, 1'b1);
        rx_byte(8'h20, 1'b1);
        rx_byte(8'h30, 1'b1);
        rx_byte(8'hEE, 1'b0);
        for (int i = 0; i < 10; i++) rx_byte(8'h40 + 8'(i), 1'b1);
        wait_rx_drain("rx_framing_drain");
        tick(TO + 100);

        // Partial word discarded after an idle gap beyond the timeout
        for (int i = 0; i < 4; i++) rx_byte(8'hC0 + 8'(i), 1'b1);
        tick(TO + 80);
        rx_expect(80'hD0D1_D2D3_D4D5_D6D7_D8D9);
        for (int i = 0; i < 10; i++) rx_byte(8'hD0 + 8'(i), 1'b1);
        wait_rx_drain("rx_timeout_drain");

        // Gap shorter than the timeout keeps the partial word
        rx_expect(80'hE0E1_E2E3_E4E5_E6E7_E8E9);
        for (int i = 0; i < 4; i++) rx_byte(8'hE0 + 8'(i), 1'b1);
        tick(TO - 80);
        for (int i = 4; i < 10; i++) rx_byte(8'hE0 + 8'(i), 1'b1);
        wait_rx_drain("rx_short_gap_drain");

        // Transmit table
        for (int i = 0; i < 3; i++) begin
            tx_send(tv[i], 1'b1);
            wait_tx_drain("tx_table_drain");
        end

        // Second request while busy is ignored; idata change has no effect
        base_tx = tx_bytes;
        tx_send(80'h1111_2222_3333_4444_5555, 1'b1);
        tick(500);
        tx_send(80'h9999_8888_7777_6666_0000, 1'b0);
        wait_tx_drain("tx_busy_drain");
        tick(300);
        check("tx_busy_count", DW'(tx_bytes - base_tx), DW'(NB));

        // Loopback, full duplex
        loop_en = 1'b1;
        tick(4);
        rx_expect(80'hDEAD_BEEF_CAFE_1234_5678);
        tx_send(80'hDEAD_BEEF_CAFE_1234_5678, 1'b1);
        wait_tx_drain("loop_tx_drain");
        wait_rx_drain("loop_rx_drain");

        // Reset in the middle of a looped-back frame
        tx_mon_en = 1'b0;
        tx_send(80'h1357_9BDF_2468_ACE0_1234, 1'b0);
        tick(300);
        rst = 1'b1;
        tick(1);
        check("rst_mid_tx", DW'(tx), DW'(1));
        check("rst_mid_dv", DW'(datavalid), '0);
        check("rst_mid_odata", odata, '0);
        rst = 1'b0;
        tick(NB * 10 * CPB + 100);
        check("post_rst_tx_idle", DW'(tx), DW'(1));
        loop_en   = 1'b0;
        tx_mon_en = 1'b1;
        tick(10);

        check("dv_count", DW'(dv_count), DW'(exp_dv));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
